class_vote_engine: RTL and testbench
====================================

CLASS_VOTE_ENGINE -- requirements
Module: class_vote_engine

Interface
REQ-001 SHALL have parameter CLAUSEN, default 10: number of clauses voting per frame.
REQ-002 SHALL have parameter CLASSN, default 10: number of classes.
REQ-003 SHALL have parameter WEIGHT_W, default 9: signed clause-to-class weight width.
REQ-004 SHALL have parameter SUM_W, default 16: signed per-class sum width; SUM_W >= WEIGHT_W.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port wr_en, input, 1: weight table write strobe.
REQ-008 SHALL have port wr_class, input, $clog2(CLASSN): target class of the weight write.
REQ-009 SHALL have port wr_clause, input, $clog2(CLAUSEN): target clause of the weight write.
REQ-010 SHALL have port wr_data, input, WEIGHT_W: signed weight value.
REQ-011 SHALL have port start, input, 1: begins a frame; sums are cleared.
REQ-012 SHALL have port cl_valid, input, 1: clause result strobe.
REQ-013 SHALL have port cl_idx, input, $clog2(CLAUSEN): clause index of the result.
REQ-014 SHALL have port cl_op, input, 1: clause output bit.
REQ-015 SHALL have port cl_last, input, 1: qualifies cl_valid as the final clause of the frame.
REQ-016 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-017 SHALL have port done, output, 1: one-cycle result-valid pulse.
REQ-018 SHALL have port class_op, output, $clog2(CLASSN): winning class index.
REQ-019 SHALL have port max_sum, output, SUM_W: signed sum of the winning class.
REQ-020 SHALL have port sat_seen, output, 1: sticky saturation flag for the current frame.

Function
REQ-021 SHALL implement the FSM states IDLE, ACCUM, SCAN and DONE.
REQ-022 Transitions SHALL be: IDLE->ACCUM on start; ACCUM->SCAN on an accepted cl_valid&&cl_last; SCAN->DONE after class CLASSN-1 is compared; DONE->IDLE unconditionally.
REQ-023 On start in IDLE, all CLASSN sums and sat_seen SHALL clear to 0 on that same edge.
REQ-024 start SHALL be ignored when not in IDLE.
REQ-025 The weight table SHALL be a CLASSN x CLAUSEN array of flops, written on wr_en only in IDLE; wr_en in any other state SHALL be ignored.
REQ-026 Writes with wr_class >= CLASSN or wr_clause >= CLAUSEN SHALL be ignored.
REQ-027 In ACCUM, on cl_valid with cl_op=1 and cl_idx < CLAUSEN, every sum[c] SHALL add the sign-extended weight[c][cl_idx] on the same edge, for all classes in parallel.
REQ-028 cl_valid outside ACCUM SHALL be ignored.
REQ-029 cl_valid with cl_idx >= CLAUSEN SHALL add nothing, but its cl_last SHALL still be honoured.
REQ-030 The last clause's contribution SHALL be included in the sums before the scan starts.
REQ-031 SCAN SHALL visit one class per cycle in order k = 0..CLASSN-1.
REQ-032 At k=0 the running max SHALL load sum[0] unconditionally; for k>0 it SHALL update only when sum[k] > max (signed, strict), so the lowest index wins ties.
REQ-033 In DONE, class_op and max_sum SHALL load from the scan result and done SHALL be high for exactly that cycle.
REQ-034 Latency: done SHALL assert CLASSN+1 cycles after the edge that accepts cl_last.
REQ-035 class_op and max_sum SHALL hold their values until the next DONE.
REQ-036 A frame with no cl_op=1 results SHALL give class_op=0 and max_sum=0.

Reset
REQ-037 While rst_n=0, the block SHALL asynchronously go to IDLE, with busy=0, done=0, class_op=0, max_sum=0, sat_seen=0, all sums=0 and all weights=0.
REQ-038 Reset asserted mid-frame SHALL abort the frame; no done pulse SHALL be produced.

Configuration
REQ-039 With CLASS_SUM_SAT_EN defined, each sum update SHALL clamp to [-2^(SUM_W-1), 2^(SUM_W-1)-1], and sat_seen SHALL set whenever any sum clamps.
REQ-040 Without CLASS_SUM_SAT_EN, sums SHALL wrap in two's complement and sat_seen SHALL be tied 0.

Verification
REQ-041 Bench SHALL cover: CLASSN=10, CLAUSEN=10, weight[c][k]=c-4 for all k, all ten clauses cl_op=1 -> done with class_op=9, max_sum=50, 11 cycles after cl_last.
REQ-042 Bench SHALL cover: all weights 0 except weight[3][2]=+7 and weight[7][2]=+7, clause 2 active -> class_op=3 (tie goes to the lower index), max_sum=7.
REQ-043 Bench SHALL cover: SUM_W=9, WEIGHT_W=9, weight[0][*]=200, two clauses active -> with macro max_sum=255, sat_seen=1; without macro sum[0]=-112, so the winning class differs.
REQ-044 Bench SHALL cover: start, wr_en and cl_valid with cl_idx=12 issued during ACCUM -> all ignored, sums and weights unchanged, frame completes normally.
REQ-045 Bench SHALL cover: rst_n pulled low during SCAN -> all outputs 0 immediately, no done pulse; a following frame produces the correct result.

Source files
------------

// File: rtl/class_vote_engine.sv
// class_vote_engine: weighted clause voting into per-class sums, then a serial argmax scan.
// Define CLASS_SUM_SAT_EN to clamp sums instead of wrapping and to drive sat_seen.
module class_vote_engine #(
  parameter int CLAUSEN  = 10,
  parameter int CLASSN   = 10,
  parameter int WEIGHT_W = 9,
  parameter int SUM_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [$clog2(CLASSN)-1:0]   wr_class,
  input  logic [$clog2(CLAUSEN)-1:0]  wr_clause,
  input  logic [WEIGHT_W-1:0]         wr_data,
  input  logic                        start,
  input  logic                        cl_valid,
  input  logic [$clog2(CLAUSEN)-1:0]  cl_idx,
  input  logic                        cl_op,
  input  logic                        cl_last,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(CLASSN)-1:0]   class_op,
  output logic [SUM_W-1:0]            max_sum,
  output logic                        sat_seen
);
  localparam int CSW = $clog2(CLASSN);
  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;
  state_t state_q;
  logic signed [WEIGHT_W-1:0] w_q [CLASSN][CLAUSEN];
  logic signed [SUM_W-1:0] sum_q [CLASSN];
  logic signed [SUM_W-1:0] add_d [CLASSN];
  logic signed [SUM_W-1:0] max_q, max_sum_q;
  logic [CSW-1:0] k_q, arg_q, class_q;
  logic [CLASSN-1:0] ovf;
  logic done_q, sat_q, hit;
  assign hit = state_q == ACCUM && cl_valid && cl_op && 32'(cl_idx) < CLAUSEN;
`ifdef CLASS_SUM_SAT_EN
  logic [SUM_W:0] ext [CLASSN];
  // One guard bit exposes overflow; clamp toward the sign of the true result.
  always_comb
    for (int c = 0; c < CLASSN; c++) begin
      ext[c] = {sum_q[c][SUM_W-1], sum_q[c]} + (SUM_W+1)'(w_q[c][cl_idx]);
      ovf[c] = ext[c][SUM_W] ^ ext[c][SUM_W-1];
      add_d[c] = ovf[c] ? {ext[c][SUM_W], {(SUM_W-1){~ext[c][SUM_W]}}} : ext[c][SUM_W-1:0];
    end
`else
  always_comb
    for (int c = 0; c < CLASSN; c++)
      add_d[c] = sum_q[c] + SUM_W'(w_q[c][cl_idx]);
  assign ovf = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      arg_q     <= '0;
      class_q   <= '0;
      max_q     <= '0;
      max_sum_q <= '0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
      for (int c = 0; c < CLASSN; c++) begin
        sum_q[c] <= '0;
        for (int k = 0; k < CLAUSEN; k++) w_q[c][k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_en && 32'(wr_class) < CLASSN && 32'(wr_clause) < CLAUSEN)
            w_q[wr_class][wr_clause] <= wr_data;
          if (start) begin
            state_q <= ACCUM;
            sat_q   <= 1'b0;
            for (int c = 0; c < CLASSN; c++) sum_q[c] <= '0;
          end
        end
        ACCUM: begin
          if (hit) begin
            for (int c = 0; c < CLASSN; c++) sum_q[c] <= add_d[c];
            sat_q <= sat_q | (|ovf);
          end
          if (cl_valid && cl_last) begin
            state_q <= SCAN;
            k_q     <= '0;
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (k_q == '0 || sum_q[k_q] > max_q) begin
            max_q <= sum_q[k_q];
            arg_q <= k_q;
          end
          k_q <= k_q + 1'b1;
          if (32'(k_q) == CLASSN - 1) state_q <= DONE;
        end
        DONE: begin
          class_q   <= arg_q;
          max_sum_q <= max_q;
          done_q    <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign class_op = class_q;
  assign max_sum  = max_sum_q;
  assign sat_seen = sat_q;
endmodule

// File: tb/tb_class_vote_engine.sv
// tb_class_vote_engine: random and directed frames against a behavioural vote model,
// driving a 16-bit-sum instance and a 9-bit-sum instance with identical stimulus.
module tb_class_vote_engine;
  localparam int CLASSN = 10, CLAUSEN = 10;
  logic clk = 0, rst_n = 0, wr_en = 0, start = 0, cl_valid = 0, cl_op = 0, cl_last = 0;
  logic [3:0] wr_class = 0, wr_clause = 0, cl_idx = 0;
  logic [8:0] wr_data = 0;
  logic busy_a, done_a, sat_a, busy_b, done_b, sat_b;
  logic [3:0] cls_a, cls_b;
  logic [15:0] max_a;
  logic [8:0] max_b;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  class_vote_engine #(.CLAUSEN(CLAUSEN), .CLASSN(CLASSN), .WEIGHT_W(9), .SUM_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_class(wr_class), .wr_clause(wr_clause),
    .wr_data(wr_data), .start(start), .cl_valid(cl_valid), .cl_idx(cl_idx), .cl_op(cl_op),
    .cl_last(cl_last), .busy(busy_a), .done(done_a), .class_op(cls_a), .max_sum(max_a),
    .sat_seen(sat_a));
  class_vote_engine #(.CLAUSEN(CLAUSEN), .CLASSN(CLASSN), .WEIGHT_W(9), .SUM_W(9)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_class(wr_class), .wr_clause(wr_clause),
    .wr_data(wr_data), .start(start), .cl_valid(cl_valid), .cl_idx(cl_idx), .cl_op(cl_op),
    .cl_last(cl_last), .busy(busy_b), .done(done_b), .class_op(cls_b), .max_sum(max_b),
    .sat_seen(sat_b));

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, act, exp, $time);
    end
  endtask

  // Behavioural model: integer sums, then wrapped or clamped to the sum width.
  int mw [CLASSN][CLAUSEN];
  longint s_a [CLASSN], s_b [CLASSN];
  bit m_acc, m_done, m_wb, f_a, f_b;
  int m_cnt, p_cls_a, p_cls_b, e_cls_a, e_cls_b;
  longint p_max_a, p_max_b, e_max_a, e_max_b;

  function automatic longint upd(input longint s, input longint d, input int w, inout bit f);
    longint lo, hi, v;
    lo = -(longint'(1) << (w - 1));
    hi = -lo - 1;
    v = s + d;
`ifdef CLASS_SUM_SAT_EN
    if (v > hi) begin v = hi; f = 1'b1; end
    else if (v < lo) begin v = lo; f = 1'b1; end
`else
    v = v & ((longint'(1) << w) - 1);
    if (v > hi) v -= longint'(1) << w;
`endif
    return v;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_acc = 0; m_cnt = 0; m_done = 0; f_a = 0; f_b = 0;
      e_cls_a = 0; e_cls_b = 0; e_max_a = 0; e_max_b = 0;
      for (int c = 0; c < CLASSN; c++) begin
        s_a[c] = 0; s_b[c] = 0;
        for (int k = 0; k < CLAUSEN; k++) mw[c][k] = 0;
      end
    end else begin
      m_wb = m_acc || m_cnt > 0;
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1;
          e_cls_a = p_cls_a; e_cls_b = p_cls_b; e_max_a = p_max_a; e_max_b = p_max_b;
        end
      end
      if (!m_wb) begin
        if (wr_en && wr_class < CLASSN && wr_clause < CLAUSEN)
          mw[wr_class][wr_clause] = int'($signed(wr_data));
        if (start) begin
          m_acc = 1; f_a = 0; f_b = 0;
          for (int c = 0; c < CLASSN; c++) begin s_a[c] = 0; s_b[c] = 0; end
        end
      end else if (m_acc && cl_valid) begin
        if (cl_op && cl_idx < CLAUSEN)
          for (int c = 0; c < CLASSN; c++) begin
            s_a[c] = upd(s_a[c], mw[c][cl_idx], 16, f_a);
            s_b[c] = upd(s_b[c], mw[c][cl_idx], 9, f_b);
          end
        if (cl_last) begin
          m_acc = 0; m_cnt = CLASSN + 1;
          p_cls_a = 0; p_cls_b = 0; p_max_a = s_a[0]; p_max_b = s_b[0];
          for (int c = 1; c < CLASSN; c++) begin
            if (s_a[c] > p_max_a) begin p_max_a = s_a[c]; p_cls_a = c; end
            if (s_b[c] > p_max_b) begin p_max_b = s_b[c]; p_cls_b = c; end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy_a", busy_a, m_acc || m_cnt > 0);
    chk("busy_b", busy_b, m_acc || m_cnt > 0);
    chk("done_a", done_a, m_done);
    chk("done_b", done_b, m_done);
    chk("class_a", cls_a, e_cls_a);
    chk("class_b", cls_b, e_cls_b);
    chk("max_a", $signed(max_a), e_max_a);
    chk("max_b", $signed(max_b), e_max_b);
    chk("sat_a", sat_a, f_a);
    chk("sat_b", sat_b, f_b);
  end

  task automatic drv(input bit we, input int wc, input int wk, input int wd, input bit st,
                     input bit cv, input int ci, input bit co, input bit cl);
    @(negedge clk);
    wr_en = we; wr_class = 4'(wc); wr_clause = 4'(wk); wr_data = 9'(wd);
    start = st; cl_valid = cv; cl_idx = 4'(ci); cl_op = co; cl_last = cl;
  endtask
  task automatic nop(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input int c, input int k, input int d); drv(1, c, k, d, 0, 0, 0, 0, 0); endtask
  task automatic st(); drv(0, 0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic cv(input int i, input bit o, input bit l); drv(0, 0, 0, 0, 0, 1, i, o, l); endtask

  // lat = edges after the cl_last-accepting edge until done is visible; 99 on timeout.
  task automatic wait_done(output int lat);
    lat = 99;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      {wr_en, start, cl_valid, cl_op, cl_last} = '0;
      if (done_a) begin lat = n; break; end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_class", cls_a, 0);
    rst_n = 1;
    // all ten clauses on, weight c-4: class 9 wins with 50
    for (int c = 0; c < CLASSN; c++)
      for (int k = 0; k < CLAUSEN; k++) wr(c, k, c - 4);
    st();
    for (int k = 0; k < CLAUSEN; k++) cv(k, 1, k == CLAUSEN - 1);
    wait_done(lat);
    chk("t1_lat", lat, 11);
    chk("t1_class", cls_a, 9);
    chk("t1_max", $signed(max_a), 50);
    chk("t1_model_class", e_cls_a, 9);
    // tie between classes 3 and 7 goes to 3
    for (int c = 0; c < CLASSN; c++)
      for (int k = 0; k < CLAUSEN; k++) wr(c, k, 0);
    wr(3, 2, 7); wr(7, 2, 7);
    st(); cv(0, 0, 0); cv(2, 1, 0); cv(5, 0, 1);
    wait_done(lat);
    chk("t2_lat", lat, 11);
    chk("t2_class", cls_a, 3);
    chk("t2_max", $signed(max_a), 7);
    // 200+200 overflows a 9-bit sum
    wr(3, 2, 0); wr(7, 2, 0);
    for (int k = 0; k < CLAUSEN; k++) wr(0, k, 200);
    st(); cv(0, 1, 0); cv(1, 1, 1);
    wait_done(lat);
    chk("t3_lat", lat, 11);
    chk("t3_class_a", cls_a, 0);
    chk("t3_max_a", $signed(max_a), 400);
    chk("t3_sat_a", sat_a, 0);
`ifdef CLASS_SUM_SAT_EN
    chk("t3_class_b", cls_b, 0);
    chk("t3_max_b", $signed(max_b), 255);
    chk("t3_sat_b", sat_b, 1);
    chk("t3_model_sum_b", s_b[0], 255);
`else
    chk("t3_class_b", cls_b, 1);
    chk("t3_max_b", $signed(max_b), 0);
    chk("t3_sat_b", sat_b, 0);
    chk("t3_model_sum_b", s_b[0], -112);
`endif
    // start, write and out-of-range clause during ACCUM are all ignored
    for (int k = 0; k < CLAUSEN; k++) wr(0, k, 0);
    wr(2, 0, 5); wr(2, 1, 5);
    st(); cv(0, 1, 0); st(); wr(5, 0, 100); cv(12, 1, 0); cv(1, 1, 0); cv(0, 1, 0); cv(12, 1, 1);
    wait_done(lat);
    chk("t4_lat", lat, 11);
    chk("t4_class", cls_a, 2);
    chk("t4_max", $signed(max_a), 15);
    // reset in the middle of SCAN
    st(); cv(0, 1, 1);
    repeat (4) nop();
    #2 rst_n = 0;
    #1;
    chk("t5_busy", busy_a, 0);
    chk("t5_class", cls_a, 0);
    chk("t5_max", $signed(max_a), 0);
    chk("t5_sat", sat_b, 0);
    seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (CLASSN + 3) begin
      @(negedge clk);
      seen |= done_a | done_b;
    end
    chk("t5_no_done", seen, 0);
    wr(6, 3, 9);
    st();
    for (int k = 0; k < CLAUSEN; k++) cv(k, 1, k == CLAUSEN - 1);
    wait_done(lat);
    chk("t5_lat", lat, 11);
    chk("t5_class_after", cls_a, 6);
    chk("t5_max_after", $signed(max_a), 9);
    // random frames with ignored traffic mixed in
    repeat (25) begin
      repeat ($urandom_range(0, 12)) wr($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 511));
      st();
      repeat ($urandom_range(0, 12)) begin
        case ($urandom_range(0, 5))
          0: nop();
          1: wr($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 511));
          2: st();
          default: cv($urandom_range(0, 15), 1'($urandom_range(0, 1)), 0);
        endcase
      end
      cv($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1);
      wait_done(lat);
      chk("rnd_lat", lat, 11);
    end
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
